// File: rtl/mem_arbiter_if.sv
// Request/RAM bus between the fetch/data ports and the arbiter.
// master = requesters plus RAM, slave = arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] iload;
  logic          iwait;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic [DW-1:0] dload;
  logic          dwait;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;
  logic          ram_err;

  modport master (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore,
    output ramload, ramstate,
    input  iload, iwait, dload, dwait,
    input  ramREN, ramWEN, ramaddr,
    input  ramstore, ram_err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore,
    input  ramload, ramstate,
    output iload, iwait, dload, dwait,
    output ramREN, ramWEN, ramaddr,
    output ramstore, ram_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported RAM.
// Data has priority; fetch is forced after MAX_DSTREAK data grants.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam int DSW = $clog2(MAX_DSTREAK + 1);
  localparam logic [DSW-1:0] DMAX = DSW'(MAX_DSTREAK);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_e;

  state_e         state_q, state_d;
  logic [DSW-1:0] dstreak_q, dstreak_d;
  logic           err_q, err_d;

  logic           dreq;
  logic           force_i;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  store;

  assign dreq = bus.dREN | bus.dWEN;
  assign force_i = bus.iREN && (dstreak_q == DMAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dstreak_d  = dstreak_q;
    err_d      = err_q;
    addr       = '0;
    store      = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.iwait  = 1'b1;
    bus.dwait  = 1'b1;
    bus.iload  = '0;
    bus.dload  = '0;
    unique case (state_q)
      IDLE: begin
        if (!bus.iREN) dstreak_d = '0;
        if (dreq && !force_i) state_d = DGNT;
        else if (bus.iREN) state_d = IGNT;
      end
      IGNT: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          addr = bus.iaddr;
          if (bus.ramstate == RS_ACCESS) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
            dstreak_d = '0;
            state_d   = IDLE;
          end
          if (bus.ramstate == RS_ERROR) err_d = 1'b1;
        end
      end
      DGNT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          // A write wins when both enables are raised.
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          addr  = bus.daddr;
          store = bus.dstore;
          if (bus.ramstate == RS_ACCESS) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramload;
            state_d   = IDLE;
            if (bus.iREN && dstreak_q != DMAX)
              dstreak_d = dstreak_q + 1'b1;
          end
          if (bus.ramstate == RS_ERROR) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.ram_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Expected completions are queued and popped when a wait drops.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] K = 32'h1234_5678;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } txn_t;

  logic CLK = 1'b0;
  logic nRST;
  int   tests = 0;
  int   fails = 0;
  txn_t iq[$];
  txn_t dq[$];

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .MAX_DSTREAK(4),
    .AW(AW),
    .DW(DW)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // RAM data model: read data is a fixed function of address.
  assign bus.ramload = bus.ramaddr ^ K;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic finish_i(string tag);
    txn_t t;
    bus.ramstate = 2'd2;
    #1;
    chk({tag, ".iwait"}, 64'(bus.iwait), 0);
    chk({tag, ".dwait"}, 64'(bus.dwait), 1);
    chk({tag, ".sb"}, 64'(iq.size() != 0), 1);
    if (iq.size() != 0) begin
      t = iq.pop_front();
      chk({tag, ".addr"}, 64'(bus.ramaddr), 64'(t.addr));
      chk({tag, ".iload"}, 64'(bus.iload), 64'(t.data));
    end
  endtask

  task automatic finish_d(string tag);
    txn_t t;
    bus.ramstate = 2'd2;
    #1;
    chk({tag, ".dwait"}, 64'(bus.dwait), 0);
    chk({tag, ".iwait"}, 64'(bus.iwait), 1);
    chk({tag, ".sb"}, 64'(dq.size() != 0), 1);
    if (dq.size() != 0) begin
      t = dq.pop_front();
      chk({tag, ".addr"}, 64'(bus.ramaddr), 64'(t.addr));
      chk({tag, ".wen"}, 64'(bus.ramWEN), 64'(t.we));
      if (t.we)
        chk({tag, ".store"}, 64'(bus.ramstore), 64'(t.data));
      else
        chk({tag, ".dload"}, 64'(bus.dload), 64'(t.data));
    end
  endtask

  initial begin
    nRST = 1'b1;
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    bus.dWEN = 1'b1;
    bus.iaddr = 32'h20;
    bus.daddr = 32'h10;
    bus.dstore = '0;
    bus.ramstate = 2'd0;
    #2 nRST = 1'b0;

    // Reset with every request raised
    repeat (2) cyc();
    #1;
    chk("t1.rst.iwait", 64'(bus.iwait), 1);
    chk("t1.rst.dwait", 64'(bus.dwait), 1);
    chk("t1.rst.ren", 64'(bus.ramREN), 0);
    chk("t1.rst.wen", 64'(bus.ramWEN), 0);
    chk("t1.rst.addr", 64'(bus.ramaddr), 0);
    chk("t1.rst.store", 64'(bus.ramstore), 0);
    chk("t1.rst.iload", 64'(bus.iload), 0);
    chk("t1.rst.dload", 64'(bus.dload), 0);
    chk("t1.rst.err", 64'(bus.ram_err), 0);
    nRST = 1'b1;
    cyc();
    #1;
    chk("t1.dgnt.wen", 64'(bus.ramWEN), 1);
    chk("t1.dgnt.ren", 64'(bus.ramREN), 0);
    chk("t1.dgnt.addr", 64'(bus.ramaddr), 32'h10);
    chk("t1.dgnt.iwait", 64'(bus.iwait), 1);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    #1;
    chk("t1.abort.wen", 64'(bus.ramWEN), 0);
    chk("t1.abort.dwait", 64'(bus.dwait), 1);
    cyc();
    #1;
    chk("t1.idle.ren", 64'(bus.ramREN), 0);

    // Single fetch, ACCESS one cycle after the enable
    bus.iREN = 1'b1;
    bus.iaddr = 32'h40;
    iq.push_back('{32'h40, 32'h40 ^ K, 1'b0});
    cyc();
    #1;
    chk("t2.c1.ren", 64'(bus.ramREN), 1);
    chk("t2.c1.addr", 64'(bus.ramaddr), 32'h40);
    chk("t2.c1.iwait", 64'(bus.iwait), 1);
    chk("t2.c1.dwait", 64'(bus.dwait), 1);
    cyc();
    finish_i("t2.c2");
    cyc();
    bus.iREN = 1'b0;
    bus.ramstate = 2'd0;
    #1;
    chk("t2.c3.ren", 64'(bus.ramREN), 0);
    chk("t2.c3.iwait", 64'(bus.iwait), 1);

    // Simultaneous fetch and data write: data first
    bus.iREN = 1'b1;
    bus.iaddr = 32'h44;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h80;
    bus.dstore = 32'hDEADBEEF;
    dq.push_back('{32'h80, 32'hDEADBEEF, 1'b1});
    iq.push_back('{32'h44, 32'h44 ^ K, 1'b0});
    cyc();
    #1;
    chk("t3.dgnt.wen", 64'(bus.ramWEN), 1);
    chk("t3.dgnt.ren", 64'(bus.ramREN), 0);
    chk("t3.dgnt.iwait", 64'(bus.iwait), 1);
    cyc();
    finish_d("t3.d");
    cyc();
    bus.dWEN = 1'b0;
    bus.ramstate = 2'd0;
    #1;
    chk("t3.gap.wen", 64'(bus.ramWEN), 0);
    chk("t3.gap.ren", 64'(bus.ramREN), 0);
    chk("t3.gap.iwait", 64'(bus.iwait), 1);
    cyc();
    #1;
    chk("t3.ignt.ren", 64'(bus.ramREN), 1);
    chk("t3.ignt.addr", 64'(bus.ramaddr), 32'h44);
    finish_i("t3.i");
    cyc();
    bus.iREN = 1'b0;
    bus.ramstate = 2'd0;
    #1;

    // Data streak bounded at four grants while fetch waits
    bus.dREN = 1'b1;
    bus.daddr = 32'h100;
    bus.iREN = 1'b1;
    bus.iaddr = 32'h200;
    for (int n = 0; n < 4; n++) begin
      dq.push_back('{32'h100, 32'h100 ^ K, 1'b0});
      cyc();
      #1;
      chk("t4.dgnt.ren", 64'(bus.ramREN), 1);
      chk("t4.dgnt.addr", 64'(bus.ramaddr), 32'h100);
      finish_d("t4.d");
      cyc();
      bus.ramstate = 2'd0;
      #1;
      chk("t4.gap.ren", 64'(bus.ramREN), 0);
    end
    iq.push_back('{32'h200, 32'h200 ^ K, 1'b0});
    cyc();
    #1;
    chk("t4.fetch.addr", 64'(bus.ramaddr), 32'h200);
    chk("t4.fetch.dwait", 64'(bus.dwait), 1);
    finish_i("t4.i");
    cyc();
    bus.ramstate = 2'd0;
    #1;
    cyc();
    #1;
    chk("t4.again.addr", 64'(bus.ramaddr), 32'h100);
    chk("t4.again.ren", 64'(bus.ramREN), 1);
    bus.dREN = 1'b0;
    bus.iREN = 1'b0;
    #1;
    chk("t4.abort.ren", 64'(bus.ramREN), 0);
    cyc();

    // BUSY x5, ERROR x1, then ACCESS on a data read
    bus.dREN = 1'b1;
    bus.daddr = 32'h300;
    dq.push_back('{32'h300, 32'h300 ^ K, 1'b0});
    cyc();
    bus.ramstate = 2'd1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t5.busy.dwait", 64'(bus.dwait), 1);
      chk("t5.busy.err", 64'(bus.ram_err), 0);
      cyc();
    end
    bus.ramstate = 2'd3;
    #1;
    chk("t5.error.dwait", 64'(bus.dwait), 1);
    chk("t5.error.err", 64'(bus.ram_err), 0);
    cyc();
    chk("t5.after.err", 64'(bus.ram_err), 1);
    finish_d("t5.d");
    cyc();
    bus.dREN = 1'b0;
    bus.ramstate = 2'd0;
    #1;

    // Data request withdrawn while RAM busy
    bus.dREN = 1'b1;
    bus.daddr = 32'h400;
    bus.iREN = 1'b1;
    bus.iaddr = 32'h500;
    cyc();
    bus.ramstate = 2'd1;
    #1;
    chk("t6.dgnt.ren", 64'(bus.ramREN), 1);
    chk("t6.dgnt.addr", 64'(bus.ramaddr), 32'h400);
    cyc();
    bus.dREN = 1'b0;
    #1;
    chk("t6.drop.ren", 64'(bus.ramREN), 0);
    chk("t6.drop.dwait", 64'(bus.dwait), 1);
    cyc();
    #1;
    chk("t6.idle.ren", 64'(bus.ramREN), 0);
    chk("t6.idle.dwait", 64'(bus.dwait), 1);
    iq.push_back('{32'h500, 32'h500 ^ K, 1'b0});
    cyc();
    #1;
    chk("t6.ignt.ren", 64'(bus.ramREN), 1);
    chk("t6.ignt.addr", 64'(bus.ramaddr), 32'h500);
    finish_i("t6.i");
    cyc();
    bus.iREN = 1'b0;
    bus.ramstate = 2'd0;
    #1;

    // Reset during a grant
    bus.dREN = 1'b1;
    bus.daddr = 32'h600;
    cyc();
    #1;
    chk("t7.dgnt.ren", 64'(bus.ramREN), 1);
    chk("t7.sticky.err", 64'(bus.ram_err), 1);
    nRST = 1'b0;
    #1;
    chk("t7.rst.ren", 64'(bus.ramREN), 0);
    chk("t7.rst.err", 64'(bus.ram_err), 0);
    chk("t7.rst.dwait", 64'(bus.dwait), 1);
    bus.dREN = 1'b0;
    cyc();
    nRST = 1'b1;
    #1;

    chk("sb.empty", 64'(iq.size() + dq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
